// File: rtl/stg_ma.sv
// stg_ma: memory-access pipeline stage between EX and WB. Loads and stores stall upstream until acked.
// Optional build macro MA_TIMEOUT_EN: aborts an unacknowledged access after 256 REQ cycles and pulses ow_fault.

`ifndef SIZE_PC
`define SIZE_PC 24
`endif
`ifndef SIZE_INSTR
`define SIZE_INSTR 24
`endif
`ifndef SIZE_OPC
`define SIZE_OPC 8
`endif
`ifndef SIZE_TGT_GP
`define SIZE_TGT_GP 4
`endif
`ifndef SIZE_TGT_SR
`define SIZE_TGT_SR 2
`endif
`ifndef SIZE_ADDR
`define SIZE_ADDR 24
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 24
`endif
`ifndef OPC_RU_LDu
`define OPC_RU_LDu 8'h20
`endif
`ifndef OPC_RU_STu
`define OPC_RU_STu 8'h21
`endif
`ifndef OPC_IU_STiu
`define OPC_IU_STiu 8'h22
`endif
`ifndef OPC_IS_STis
`define OPC_IS_STis 8'h23
`endif

module stg_ma (
   input  logic                    iw_clk,
   input  logic                    iw_rst,
   input  logic [`SIZE_PC-1:0]     iw_pc,
   input  logic [`SIZE_INSTR-1:0]  iw_instr,
   input  logic [`SIZE_OPC-1:0]    iw_opc,
   input  logic [`SIZE_TGT_GP-1:0] iw_tgt_gp,
   input  logic                    iw_tgt_gp_we,
   input  logic [`SIZE_TGT_SR-1:0] iw_tgt_sr,
   input  logic                    iw_tgt_sr_we,
   input  logic [`SIZE_ADDR-1:0]   iw_addr,
   input  logic [`SIZE_DATA-1:0]   iw_result,
   output logic                    ow_stall,
   output logic                    ow_mem_req,
   output logic                    ow_mem_we,
   output logic [`SIZE_ADDR-1:0]   ow_mem_addr,
   output logic [`SIZE_DATA-1:0]   ow_mem_wdata,
   input  logic                    iw_mem_ack,
   input  logic [`SIZE_DATA-1:0]   iw_mem_rdata,
   output logic [`SIZE_PC-1:0]     ow_pc,
   output logic [`SIZE_INSTR-1:0]  ow_instr,
   output logic [`SIZE_OPC-1:0]    ow_opc,
   output logic [`SIZE_TGT_GP-1:0] ow_tgt_gp,
   output logic                    ow_tgt_gp_we,
   output logic [`SIZE_TGT_SR-1:0] ow_tgt_sr,
   output logic                    ow_tgt_sr_we,
   output logic [`SIZE_DATA-1:0]   ow_result,
   output logic                    ow_fault
);

   typedef enum logic {IDLE, REQ} state_t;

   state_t                    state;
   logic                      is_ld;
   logic                      is_st;
   logic                      is_mem;
   logic                      to_hit;

   logic [`SIZE_PC-1:0]       l_pc;
   logic [`SIZE_INSTR-1:0]    l_instr;
   logic [`SIZE_OPC-1:0]      l_opc;
   logic [`SIZE_TGT_GP-1:0]   l_tgt_gp;
   logic                      l_tgt_gp_we;
   logic [`SIZE_TGT_SR-1:0]   l_tgt_sr;
   logic                      l_tgt_sr_we;
   logic                      l_ld;

   always_comb begin
      is_ld  = (iw_opc == `OPC_RU_LDu);
      is_st  = (iw_opc == `OPC_RU_STu) || (iw_opc == `OPC_IU_STiu) ||
               (iw_opc == `OPC_IS_STis);
      is_mem = is_ld | is_st;
   end

`ifdef MA_TIMEOUT_EN
   logic [7:0] to_cnt;
   assign to_hit = (state == REQ) && !iw_mem_ack && (to_cnt == 8'hFF);
`else
   assign to_hit   = 1'b0;
   assign ow_fault = 1'b0;
`endif

   // Request comes straight from the state flop so reset drops it without a clock edge.
   assign ow_mem_req = (state == REQ);

   always_comb begin
      ow_stall = 1'b0;
      if (state == IDLE)
         ow_stall = is_mem;
      else
         ow_stall = ~iw_mem_ack & ~to_hit;
   end

   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         state        <= IDLE;
         l_pc         <= '0;
         l_instr      <= '0;
         l_opc        <= '0;
         l_tgt_gp     <= '0;
         l_tgt_gp_we  <= 1'b0;
         l_tgt_sr     <= '0;
         l_tgt_sr_we  <= 1'b0;
         l_ld         <= 1'b0;
         ow_mem_we    <= 1'b0;
         ow_mem_addr  <= '0;
         ow_mem_wdata <= '0;
         ow_pc        <= '0;
         ow_instr     <= '0;
         ow_opc       <= '0;
         ow_tgt_gp    <= '0;
         ow_tgt_gp_we <= 1'b0;
         ow_tgt_sr    <= '0;
         ow_tgt_sr_we <= 1'b0;
         ow_result    <= '0;
`ifdef MA_TIMEOUT_EN
         to_cnt       <= '0;
         ow_fault     <= 1'b0;
`endif
      end else begin
`ifdef MA_TIMEOUT_EN
         ow_fault <= 1'b0;
`endif
         if (state == IDLE) begin
            if (is_mem) begin
               // Address and store data are held in the memory-port registers for the whole access.
               l_pc         <= iw_pc;
               l_instr      <= iw_instr;
               l_opc        <= iw_opc;
               l_tgt_gp     <= iw_tgt_gp;
               l_tgt_gp_we  <= iw_tgt_gp_we;
               l_tgt_sr     <= iw_tgt_sr;
               l_tgt_sr_we  <= iw_tgt_sr_we;
               l_ld         <= is_ld;
               ow_mem_we    <= is_st;
               ow_mem_addr  <= iw_addr;
               ow_mem_wdata <= iw_result;
               ow_tgt_gp_we <= 1'b0;
               ow_tgt_sr_we <= 1'b0;
`ifdef MA_TIMEOUT_EN
               to_cnt       <= '0;
`endif
               state        <= REQ;
            end else begin
               ow_pc        <= iw_pc;
               ow_instr     <= iw_instr;
               ow_opc       <= iw_opc;
               ow_tgt_gp    <= iw_tgt_gp;
               ow_tgt_gp_we <= iw_tgt_gp_we;
               ow_tgt_sr    <= iw_tgt_sr;
               ow_tgt_sr_we <= iw_tgt_sr_we;
               ow_result    <= iw_result;
            end
         end else begin
            if (iw_mem_ack) begin
               ow_pc        <= l_pc;
               ow_instr     <= l_instr;
               ow_opc       <= l_opc;
               ow_tgt_gp    <= l_tgt_gp;
               ow_tgt_gp_we <= l_tgt_gp_we;
               ow_tgt_sr    <= l_tgt_sr;
               ow_tgt_sr_we <= l_tgt_sr_we;
               ow_result    <= l_ld ? iw_mem_rdata : ow_mem_wdata;
               ow_mem_we    <= 1'b0;
               state        <= IDLE;
            end
`ifdef MA_TIMEOUT_EN
            else if (to_hit) begin
               ow_result    <= '0;
               ow_tgt_gp_we <= 1'b0;
               ow_tgt_sr_we <= 1'b0;
               ow_mem_we    <= 1'b0;
               ow_fault     <= 1'b1;
               state        <= IDLE;
            end else begin
               to_cnt <= to_cnt + 8'd1;
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_stg_ma.sv
// tb_stg_ma: randomized scoreboard bench for stg_ma with a behavioural memory responder.
// Define MA_TIMEOUT_EN for both files to exercise the access-abort path.

`timescale 1ns/1ps

module tb_stg_ma;

   localparam logic [7:0] OPC_LD  = 8'h20;
   localparam logic [7:0] OPC_ST  = 8'h21;
   localparam logic [7:0] OPC_STI = 8'h22;
   localparam logic [7:0] OPC_STS = 8'h23;
   localparam logic [7:0] OPC_ADD = 8'h01;

   typedef struct packed {
      logic [23:0] pc;
      logic [23:0] instr;
      logic [7:0]  opc;
      logic [3:0]  gp;
      logic        gp_we;
      logic [1:0]  sr;
      logic        sr_we;
      logic [23:0] addr;
      logic [23:0] res;
   } op_t;

   typedef struct packed {
      logic [23:0] pc;
      logic [23:0] instr;
      logic [7:0]  opc;
      logic [3:0]  gp;
      logic        gp_we;
      logic [1:0]  sr;
      logic        sr_we;
      logic [23:0] result;
   } wb_t;

   typedef struct packed {
      logic [23:0] addr;
      logic        we;
      logic [23:0] wdata;
   } mem_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] pc, instr, addr, res;
   logic [7:0]  opc;
   logic [3:0]  gp;
   logic        gp_we, sr_we;
   logic [1:0]  sr;
   logic        stall, mreq, mwe, mack, fault;
   logic [23:0] maddr, mwdata, mrdata;
   logic [23:0] o_pc, o_instr, o_result;
   logic [7:0]  o_opc;
   logic [3:0]  o_gp;
   logic        o_gp_we, o_sr_we;
   logic [1:0]  o_sr;

   logic man_mode = 1'b0;
   logic man_ack  = 1'b0;
   logic resp_ack = 1'b0;
   logic armed    = 1'b0;
   int   force_lat = -1;
   int   n_cmp = 0;
   int   n_bad = 0;

   wb_t  sbq[$];
   mem_t mq[$];

   function automatic logic [23:0] mem_rd(input logic [23:0] a);
      return a ^ 24'hABCDAF;
   endfunction

   assign mack   = man_mode ? man_ack : resp_ack;
   assign mrdata = mem_rd(maddr);

   always #5 clk = ~clk;

   stg_ma dut (
      .iw_clk(clk), .iw_rst(rst),
      .iw_pc(pc), .iw_instr(instr), .iw_opc(opc),
      .iw_tgt_gp(gp), .iw_tgt_gp_we(gp_we), .iw_tgt_sr(sr), .iw_tgt_sr_we(sr_we),
      .iw_addr(addr), .iw_result(res),
      .ow_stall(stall),
      .ow_mem_req(mreq), .ow_mem_we(mwe), .ow_mem_addr(maddr), .ow_mem_wdata(mwdata),
      .iw_mem_ack(mack), .iw_mem_rdata(mrdata),
      .ow_pc(o_pc), .ow_instr(o_instr), .ow_opc(o_opc),
      .ow_tgt_gp(o_gp), .ow_tgt_gp_we(o_gp_we), .ow_tgt_sr(o_sr), .ow_tgt_sr_we(o_sr_we),
      .ow_result(o_result), .ow_fault(fault)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic is_mem_op(input logic [7:0] o);
      return (o == OPC_LD) || (o == OPC_ST) || (o == OPC_STI) || (o == OPC_STS);
   endfunction

   function automatic wb_t model_wb(input op_t o);
      wb_t w;
      w.pc     = o.pc;
      w.instr  = o.instr;
      w.opc    = o.opc;
      w.gp     = o.gp;
      w.gp_we  = o.gp_we;
      w.sr     = o.sr;
      w.sr_we  = o.sr_we;
      w.result = (o.opc == OPC_LD) ? mem_rd(o.addr) : o.res;
      return w;
   endfunction

   function automatic wb_t dut_wb();
      return {o_pc, o_instr, o_opc, o_gp, o_gp_we, o_sr, o_sr_we, o_result};
   endfunction

   function automatic op_t rand_op();
      op_t o;
      int  k;
      k       = int'($urandom_range(0, 5));
      o.pc    = 24'($urandom);
      o.instr = 24'($urandom);
      o.gp    = 4'($urandom);
      o.gp_we = 1'($urandom);
      o.sr    = 2'($urandom);
      o.sr_we = 1'($urandom);
      o.addr  = 24'($urandom);
      o.res   = 24'($urandom);
      case (k)
         0:       o.opc = OPC_LD;
         1:       o.opc = OPC_ST;
         2:       o.opc = OPC_STI;
         3:       o.opc = OPC_STS;
         default: o.opc = 8'($urandom_range(0, 31));
      endcase
      return o;
   endfunction

   task automatic drive(input op_t o);
      pc = o.pc; instr = o.instr; opc = o.opc;
      gp = o.gp; gp_we = o.gp_we; sr = o.sr; sr_we = o.sr_we;
      addr = o.addr; res = o.res;
   endtask

   // Upstream view: the presented op is taken at the first edge where stall was low.
   task automatic issue_op(input op_t o, output int sc);
      mem_t m;
      logic s;
      logic done;
      drive(o);
      sbq.push_back(model_wb(o));
      if (is_mem_op(o.opc)) begin
         m.addr  = o.addr;
         m.we    = (o.opc != OPC_LD);
         m.wdata = o.res;
         mq.push_back(m);
      end
      armed = 1'b1;
      sc    = 0;
      done  = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         #2 s = stall;
         @(posedge clk);
         #1;
         if (s) sc++;
         else   done = 1'b1;
      end
      if (!done) chk("accept_bound", 128'(done), 128'(1));
   endtask

   // Monitor: one WB result per accepted op; bubble write-enables while the stage is stalled.
   initial begin
      logic prev_v;
      logic prev_s;
      wb_t  e;
      prev_v = 1'b0;
      prev_s = 1'b0;
      forever begin
         @(negedge clk);
         if (!armed) begin
            prev_v = 1'b0;
         end else begin
            if (prev_v && !prev_s) begin
               chk("sb_nonempty", 128'(sbq.size() != 0), 128'(1));
               if (sbq.size() != 0) begin
                  e = sbq.pop_front();
                  chk("wb", 128'(dut_wb()), 128'(e));
                  chk("fault_idle", 128'(fault), 128'(0));
               end
            end else if (prev_v) begin
               chk("bubble_we", 128'({o_gp_we, o_sr_we}), 128'(0));
            end
            #2 prev_s = stall;
            prev_v = 1'b1;
         end
      end
   end

   // Memory responder: acks after a per-access latency, checks the access and its request length.
   initial begin
      logic in_req;
      int   rcnt;
      int   lat;
      mem_t cur;
      in_req = 1'b0;
      rcnt   = 0;
      lat    = 0;
      cur    = '0;
      forever begin
         @(negedge clk);
         if (man_mode || rst) begin
            in_req   = 1'b0;
            resp_ack = 1'b0;
         end else if (mreq) begin
            if (!in_req) begin
               in_req = 1'b1;
               rcnt   = 0;
               lat    = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
               chk("mem_expected", 128'(mq.size() != 0), 128'(1));
               cur = (mq.size() != 0) ? mq.pop_front() : '0;
            end
            chk("mem_access", 128'({maddr, mwe, mwdata}), 128'(cur));
            resp_ack = (rcnt == lat);
            rcnt++;
         end else begin
            if (in_req) begin
               chk("req_len", 128'(rcnt), 128'(lat + 1));
               in_req = 1'b0;
            end
            resp_ack = ($urandom_range(0, 3) == 0);
         end
      end
   end

   initial begin
      op_t op;
      int  sc;
      int  rc;
      logic fseen, st255, st256;

      drive('0);
      repeat (2) @(negedge clk);
      chk("rst_wb", 128'(dut_wb()), 128'(0));
      chk("rst_mem", 128'({mreq, mwe, maddr, mwdata}), 128'(0));
      chk("rst_fault", 128'(fault), 128'(0));
      chk("rst_stall", 128'(stall), 128'(0));
      rst = 1'b0;
      @(posedge clk);
      #1;

      op = '0; op.opc = OPC_ADD; op.pc = 24'h000100; op.gp = 4'd3;
      op.gp_we = 1'b1; op.res = 24'h000123;
      issue_op(op, sc);
      chk("add_stall_cycles", 128'(sc), 128'(0));

      op = '0; op.opc = OPC_LD; op.pc = 24'h000104; op.gp = 4'd5;
      op.gp_we = 1'b1; op.addr = 24'h000040;
      force_lat = 2;
      issue_op(op, sc);
      chk("ld_stall_cycles", 128'(sc), 128'(3));

      op = '0; op.opc = OPC_STI; op.pc = 24'h000108;
      op.addr = 24'h000010; op.res = 24'h000055;
      force_lat = 0;
      issue_op(op, sc);
      chk("sti_stall_cycles", 128'(sc), 128'(1));

      force_lat = -1;
      op = rand_op(); op.opc = OPC_LD; issue_op(op, sc);
      op = rand_op(); op.opc = OPC_ST; issue_op(op, sc);

      for (int i = 0; i < 300; i++) begin
         op = rand_op();
         issue_op(op, sc);
      end
      drive('0);
      @(negedge clk);
      #3 armed = 1'b0;
      chk("sb_drain", 128'(sbq.size()), 128'(0));
      chk("mq_drain", 128'(mq.size()), 128'(0));

`ifdef MA_TIMEOUT_EN
      man_mode = 1'b1;
      man_ack  = 1'b0;
      @(posedge clk);
      #1;
      op = '0; op.opc = OPC_LD; op.addr = 24'h000200; op.gp_we = 1'b1; op.res = 24'h000777;
      drive(op);
      rc = 0; fseen = 1'b0; st255 = 1'b0; st256 = 1'b1;
      for (int i = 0; i < 400 && rc < 256; i++) begin
         @(negedge clk);
         if (fault) fseen = 1'b1;
         if (mreq) begin
            rc++;
            if (rc == 255) st255 = stall;
            if (rc == 256) st256 = stall;
         end
      end
      chk("to_req_cycles", 128'(rc), 128'(256));
      chk("to_stall_255", 128'(st255), 128'(1));
      chk("to_stall_256", 128'(st256), 128'(0));
      chk("to_fault_early", 128'(fseen), 128'(0));
      @(posedge clk);
      #1 drive('0);
      @(negedge clk);
      chk("to_fault", 128'(fault), 128'(1));
      chk("to_req_low", 128'(mreq), 128'(0));
      chk("to_we", 128'({o_gp_we, o_sr_we}), 128'(0));
      chk("to_result", 128'(o_result), 128'(0));
      @(negedge clk);
      chk("to_fault_pulse", 128'(fault), 128'(0));
      chk("to_idle", 128'(mreq), 128'(0));

      op.addr = 24'h000300;
      drive(op);
      rc = 0;
      for (int i = 0; i < 400 && rc < 256; i++) begin
         @(negedge clk);
         if (mreq) rc++;
         if (rc == 256) man_ack = 1'b1;
      end
      chk("ack256_cycles", 128'(rc), 128'(256));
      @(posedge clk);
      #1 man_ack = 1'b0;
      drive('0);
      @(negedge clk);
      chk("ack256_fault", 128'(fault), 128'(0));
      chk("ack256_result", 128'(o_result), 128'(mem_rd(24'h000300)));
      chk("ack256_gp_we", 128'(o_gp_we), 128'(1));
      chk("ack256_req", 128'(mreq), 128'(0));
`endif

      man_mode = 1'b1;
      man_ack  = 1'b0;
      @(posedge clk);
      #1;
      op = '0; op.opc = OPC_LD; op.addr = 24'h000044; op.gp_we = 1'b1;
      drive(op);
      @(negedge clk);
      @(negedge clk);
      chk("rst_req_pre", 128'(mreq), 128'(1));
      #1 rst = 1'b1;
      drive('0);
      #1;
      chk("rst_req_async", 128'(mreq), 128'(0));
      chk("rst_mem_async", 128'({mwe, maddr, mwdata}), 128'(0));
      chk("rst_wb_async", 128'(dut_wb()), 128'(0));
      chk("rst_fault_async", 128'(fault), 128'(0));
      chk("rst_stall_async", 128'(stall), 128'(0));
      @(negedge clk);
      rst = 1'b0;
      man_ack = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("late_ack_req", 128'(mreq), 128'(0));
         chk("late_ack_wb", 128'(dut_wb()), 128'(0));
      end
      man_ack = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/stg_ma.md
STG_MA -- requirements
Module: stg_ma

Interface
REQ-001 SHALL have ports, clock and reset first: iw_clk in 1 clock; iw_rst in 1 reset, asynchronous, active-high.
REQ-002 SHALL have EX-side inputs: iw_pc, iw_instr, iw_opc, iw_tgt_gp, iw_tgt_gp_we, iw_tgt_sr, iw_tgt_sr_we, iw_addr, iw_result, each in with the matching `SIZE_* width (data and addr 24 bits).
REQ-003 SHALL have output ow_stall (out, 1), which freezes the upstream pipeline registers when high.
REQ-004 SHALL have memory port: ow_mem_req out 1; ow_mem_we out 1; ow_mem_addr out 24; ow_mem_wdata out 24; iw_mem_ack in 1; iw_mem_rdata in 24.
REQ-005 SHALL have WB-side outputs: ow_pc, ow_instr, ow_opc, ow_tgt_gp, ow_tgt_gp_we, ow_tgt_sr, ow_tgt_sr_we, ow_result (24), with widths matching the corresponding inputs.
REQ-006 SHALL have output ow_fault (out, 1), a one-cycle access-abort pulse.

Function
REQ-007 SHALL classify OPC_RU_LDu as a load and OPC_RU_STu, OPC_IU_STiu, OPC_IS_STis as stores; all other opcodes are non-memory.
REQ-008 SHALL implement FSM states IDLE and REQ; reset state is IDLE.
REQ-009 Non-memory op in IDLE: SHALL register all EX inputs to the WB outputs on the next edge (latency 1), with ow_result = iw_result.
REQ-010 Memory op in IDLE: SHALL latch the op's fields, addr, and result (the store data), and go to REQ; on that edge the WB outputs SHALL load a bubble (ow_tgt_gp_we = 0, ow_tgt_sr_we = 0, other fields unchanged).
REQ-011 ow_mem_req SHALL equal (state == REQ) and SHALL be driven from state only.
REQ-012 In REQ, ow_mem_addr and ow_mem_wdata SHALL come from the latched values, and ow_mem_we SHALL be 1 for stores and 0 for loads; all three SHALL be stable while ow_mem_req is high.
REQ-013 ow_stall SHALL be combinational: (IDLE and incoming memory op) or (REQ and not iw_mem_ack); it SHALL be 0 in all other cases.
REQ-014 In REQ, EX inputs SHALL be ignored.
REQ-015 On REQ with iw_mem_ack = 1: the next edge SHALL return to IDLE and load the latched fields to the WB outputs.
REQ-016 On that completion edge, ow_result SHALL be iw_mem_rdata for a load and the latched store data for a store.
REQ-017 Minimum memory-op latency SHALL be 2 cycles from the op being presented to the WB outputs updating, assuming ack in the first REQ cycle.
REQ-018 iw_mem_ack in IDLE SHALL be ignored.
REQ-019 Back-to-back memory ops SHALL each pass through IDLE for one cycle; ow_mem_req drops for at least one cycle between accesses.
REQ-020 ow_fault SHALL be 0 except as given in REQ-024.

Reset
REQ-021 On iw_rst, the block SHALL asynchronously set state IDLE and clear all latches and counters.
REQ-022 On iw_rst, all registered outputs SHALL go to 0, including ow_mem_req, ow_mem_we, ow_mem_addr, ow_mem_wdata, ow_fault and all WB outputs.
REQ-023 Reset in REQ SHALL drop ow_mem_req immediately, without waiting for a clock edge; the pending access is discarded and no WB write results.

Configuration
REQ-024 With macro MA_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to REQ and increment every REQ cycle without ack. In a REQ cycle where the count is 255 and there is no ack: ow_stall = 0, and the next edge SHALL go to IDLE, write ow_result = 0, ow_tgt_gp_we = 0 and ow_tgt_sr_we = 0, and pulse ow_fault high for one cycle. An ack in that same cycle SHALL take priority and complete normally.
REQ-025 Without MA_TIMEOUT_EN, REQ SHALL wait indefinitely for ack, no counter SHALL be synthesized, and ow_fault SHALL be tied 0.

Verification
REQ-026 ADDu (iw_result = 24'h000123, iw_tgt_gp_we = 1) in IDLE -> next cycle ow_result = 24'h000123, ow_tgt_gp_we = 1; ow_stall and ow_mem_req stay 0.
REQ-027 LDu (iw_addr = 24'h000040), memory acks 3 cycles after req with rdata 24'hABCDEF -> req high exactly 3 cycles with we = 0 and addr 24'h000040; stall high 3 cycles; then ow_result = 24'hABCDEF, ow_tgt_gp_we = 1.
REQ-028 STiu (iw_addr = 24'h000010, iw_result = 24'h000055), ack in the first cycle -> one req cycle with we = 1, wdata 24'h000055; WB ow_result = 24'h000055.
REQ-029 LD then ST back-to-back -> two req pulses separated by at least one low cycle; the WB outputs show one bubble per op and then each result, in order.
REQ-030 iw_rst asserted mid-REQ -> ow_mem_req low before the next edge; all outputs 0; a late ack after reset is ignored.
REQ-031 MA_TIMEOUT_EN defined, no ack -> after 256 REQ cycles: ow_fault pulses once, ow_tgt_gp_we = 0, ow_result = 0, state IDLE; ack in the 256th cycle -> normal completion and ow_fault = 0.
